pipeline_biss_et4_acc: RTL and testbench
========================================

// Module: pipeline_biss_et4_acc
// PURPOSE
// Fourth stage of the biss pipeline; sits directly downstream of pipeline_biss_et3 and consumes d.
// Keeps a running sum of valid d samples and pushes each updated sum into a DEPTH-entry
// show-ahead FIFO, drained by a ready/valid consumer. et3 cannot stall, so samples that
// arrive while the FIFO cannot accept them are dropped and counted.
// PARAMETERS
// WIDTH  16  width of input sample d
// ACC_W  24  accumulator / output width (ACC_W >= WIDTH), arithmetic modulo 2^ACC_W
// DEPTH  4   FIFO entries, power of two, >= 2
// PORTS
// clk       in   1              rising-edge clock
// rst       in   1              synchronous reset, active-high
// d         in   WIDTH          sample from et3
// d_valid   in   1              d carries a sample this cycle
// clr       in   1              synchronous accumulator clear
// e         out  ACC_W          FIFO head (running sum); 0 when FIFO empty
// e_valid   out  1              FIFO not empty
// e_ready   in   1              consumer pops head when e_valid & e_ready
// count     out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
// full      out  1              count == DEPTH
// ovf       out  1              sticky: accumulator wrapped at least once
// drop_cnt  out  8              dropped samples, saturates at 255
// BEHAVIOUR
// - Reset (rst=1 at edge): acc=0, rd/wr pointers=0, count=0, e_valid=0, e=0, full=0, ovf=0,
//   drop_cnt=0. Reset mid-operation discards all FIFO contents; an in-flight sample is dropped
//   and not counted. rst has priority over every other input.
// - pop = e_valid & e_ready. accept = d_valid & (!full | pop): a full FIFO accepts a sample
//   in the same cycle as a pop.
// - base = clr ? 0 : acc. On accept: sum = base + zero_ext(d) (ACC_W+1 bits); acc <= sum[ACC_W-1:0];
//   same value written at wr_ptr; ovf <= ovf | sum[ACC_W]. On !accept & clr: acc <= 0.
// - On d_valid & !accept: acc unchanged (clr still applies), drop_cnt += 1 unless 255.
// - Latency: sample accepted at edge N -> e_valid=1 and e=new sum after edge N (1 cycle)
//   when FIFO was empty; otherwise it appears once older entries are popped, in order.
// - e is combinational from mem[rd_ptr] (show-ahead), gated to 0 when empty.
// - Pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0. count: +1 on accept only, -1 on pop
//   only, unchanged on both. Pop on empty impossible (e_valid=0); push on full only with pop.
// - d, clr ignored while rst=1. No combinational path from d/d_valid to any output.
// TESTING
// 1. Reset 2 cycles, e_ready=1, d_valid=1, d=1..6 on consecutive cycles -> e=1,3,6,10,15,21
//    each one cycle after its sample; count<=1; drop_cnt=0.
// 2. e_ready=0, five samples d=1 -> count=4, full=1, drop_cnt=1, acc=4; then e_ready=1 ->
//    e=1,2,3,4 drained in order, e_valid=0 after the fourth pop.
// 3. FIFO full, e_ready=1 and d_valid=1 with d=9 same cycle -> head popped, sample accepted,
//    count stays 4, drop_cnt unchanged, new tail = previous acc+9.
// 4. 257 samples d=16'hFFFF, e_ready=1 -> final e=24'h00FEFF, ovf=1 and stays 1 until rst.
// 5. acc=100, clr=1 with d_valid=1, d=7 -> e=7; clr=1 with d_valid=0 -> acc=0, no FIFO push.
// 6. Three entries queued, e_ready=0, rst=1 one cycle -> e_valid=0, e=0, count=0, ovf=0,
//    drop_cnt=0; next sample d=5 -> e=5.

Source files
------------

// File: rtl/pipeline_biss_et4_acc.sv
// Fourth biss pipeline stage: running sum of et3 samples queued into a show-ahead FIFO.
// Samples that arrive while the FIFO cannot take them are dropped and counted.
module pipeline_biss_et4_acc #(
    parameter int WIDTH = 16,
    parameter int ACC_W = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         d,
    input  logic                     d_valid,
    input  logic                     clr,
    output logic [ACC_W-1:0]         e,
    output logic                     e_valid,
    input  logic                     e_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     ovf,
    output logic [7:0]               drop_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             pop;
    logic             accept;
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   sum;

    assign e_valid = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign pop     = e_valid & e_ready;
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign accept  = d_valid & (~full | pop);
    assign base    = clr ? '0 : acc;
    assign sum     = {1'b0, base} + (ACC_W+1)'(d);
    assign e       = e_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (accept) begin
                acc    <= sum[ACC_W-1:0];
                ovf    <= ovf | sum[ACC_W];
                wr_ptr <= wr_ptr + PW'(1);
            end else if (clr) begin
                acc <= '0;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (d_valid && !accept && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            mem[wr_ptr] <= sum[ACC_W-1:0];
        end
    end

endmodule

// File: tb/tb_pipeline_biss_et4_acc.sv
// Bench for pipeline_biss_et4_acc: directed scenarios plus randomized traffic
// checked against a queue-based running-sum model.
module tb_pipeline_biss_et4_acc;
    localparam int WIDTH = 16;
    localparam int ACC_W = 24;
    localparam int DEPTH = 4;
    localparam longint MOD = 64'd1 << ACC_W;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic             clr;
    logic [ACC_W-1:0] e;
    logic             e_valid;
    logic             e_ready;
    logic [2:0]       count;
    logic             full;
    logic             ovf;
    logic [7:0]       drop_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    longint           m_acc;
    logic [ACC_W-1:0] m_q[$];
    bit               m_ovf;
    int               m_drop;

    pipeline_biss_et4_acc #(.WIDTH(WIDTH), .ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .clr(clr),
        .e(e), .e_valid(e_valid), .e_ready(e_ready), .count(count),
        .full(full), .ovf(ovf), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [ACC_W-1:0] exp_head();
        return (m_q.size() != 0) ? m_q[0] : '0;
    endfunction

    // Drive one cycle of inputs, advance the model, then settle 1ns past the edge.
    task automatic drive(input bit r, input bit dv, input logic [WIDTH-1:0] dd,
                         input bit cl, input bit rdy);
        bit     p;
        bit     a;
        longint s;
        rst = r; d_valid = dv; d = dd; clr = cl; e_ready = rdy;
        if (r) begin
            m_acc = 0; m_q.delete(); m_ovf = 0; m_drop = 0;
        end else begin
            p = (m_q.size() != 0) && rdy;
            a = dv && ((m_q.size() < DEPTH) || p);
            if (p) void'(m_q.pop_front());
            if (a) begin
                s = (cl ? 0 : m_acc) + longint'(dd);
                if (s >= MOD) m_ovf = 1;
                m_acc = s % MOD;
                m_q.push_back(ACC_W'(m_acc));
            end else begin
                if (cl) m_acc = 0;
                if (dv && m_drop < 255) m_drop++;
            end
        end
        @(posedge clk);
        #1;
        rst = 0; d_valid = 0; clr = 0;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(1, 1, 16'($urandom), 1'($urandom), 1);
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL reset_e_valid got %b exp 0", e_valid); end
        checks++; if (e !== '0) begin errors++; $display("FAIL reset_e got %0h exp 0", e); end
        checks++; if (count !== 3'd0 || full !== 1'b0) begin errors++; $display("FAIL reset_count got %0d/%b exp 0/0", count, full); end
        checks++; if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_flags got ovf=%b drop=%0d exp 0/0", ovf, drop_cnt); end
    endtask

    task automatic test_stream();
        logic [ACC_W-1:0] want [6];
        want = '{24'd1, 24'd3, 24'd6, 24'd10, 24'd15, 24'd21};
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 16'(i + 1), 0, 1);
            checks++; if (e !== want[i] || e_valid !== 1'b1) begin errors++; $display("FAIL stream_e[%0d] got %0d v=%b exp %0d v=1", i, e, e_valid, want[i]); end
            checks++; if (count > 3'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d exp <=1", i, count); end
        end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL stream_drop got %0d exp 0", drop_cnt); end
    endtask

    task automatic test_full_drain();
        do_reset(1);
        for (int i = 0; i < 5; i++) drive(0, 1, 16'd1, 0, 0);
        checks++; if (count !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL full_count got %0d/%b exp 4/1", count, full); end
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL full_drop got %0d exp 1", drop_cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (e !== ACC_W'(i + 1) || e !== exp_head()) begin errors++; $display("FAIL drain_e[%0d] got %0d exp %0d", i, e, i + 1); end
            drive(0, 0, 16'd0, 0, 1);
        end
        checks++; if (e_valid !== 1'b0 || e !== '0) begin errors++; $display("FAIL drain_empty got v=%b e=%0h exp 0/0", e_valid, e); end
    endtask

    task automatic test_full_push_pop();
        do_reset(1);
        for (int i = 0; i < 4; i++) drive(0, 1, 16'd1, 0, 0);
        drive(0, 1, 16'd9, 0, 1);
        checks++; if (count !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL pushpop_count got %0d exp 4", count); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL pushpop_drop got %0d exp 0", drop_cnt); end
        checks++; if (e !== 24'd2) begin errors++; $display("FAIL pushpop_head got %0d exp 2", e); end
        for (int i = 0; i < 3; i++) drive(0, 0, 16'd0, 0, 1);
        checks++; if (e !== 24'd13) begin errors++; $display("FAIL pushpop_tail got %0d exp 13", e); end
        drive(0, 0, 16'd0, 0, 1);
    endtask

    task automatic test_wrap();
        do_reset(1);
        for (int i = 0; i < 257; i++) drive(0, 1, 16'hFFFF, 0, 1);
        checks++; if (e !== 24'h00FEFF) begin errors++; $display("FAIL wrap_e got %0h exp 00feff", e); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL wrap_ovf got %b exp 1", ovf); end
        for (int i = 0; i < 5; i++) drive(0, 1, 16'd1, 0, 1);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL wrap_ovf_sticky got %b exp 1", ovf); end
    endtask

    task automatic test_clear();
        do_reset(1);
        drive(0, 1, 16'd100, 0, 1);
        drive(0, 1, 16'd7, 1, 1);
        checks++; if (e !== 24'd7) begin errors++; $display("FAIL clr_push got %0d exp 7", e); end
        drive(0, 1, 16'd50, 0, 0);
        drive(0, 0, 16'd0, 1, 0);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL clr_nopush got count %0d exp 2", count); end
        drive(0, 0, 16'd0, 0, 1);
        drive(0, 0, 16'd0, 0, 1);
        drive(0, 1, 16'd5, 0, 1);
        checks++; if (e !== 24'd5) begin errors++; $display("FAIL clr_acc_zero got %0d exp 5", e); end
        drive(0, 0, 16'd0, 0, 1);
    endtask

    task automatic test_mid_reset();
        do_reset(1);
        for (int i = 0; i < 3; i++) drive(0, 1, 16'd3, 0, 0);
        drive(1, 1, 16'd11, 0, 0);
        checks++; if (e_valid !== 1'b0 || e !== '0 || count !== 3'd0) begin errors++; $display("FAIL midrst_state got v=%b e=%0h cnt=%0d exp 0/0/0", e_valid, e, count); end
        checks++; if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL midrst_flags got %b/%0d exp 0/0", ovf, drop_cnt); end
        drive(0, 1, 16'd5, 0, 1);
        checks++; if (e !== 24'd5) begin errors++; $display("FAIL midrst_next got %0d exp 5", e); end
    endtask

    task automatic test_drop_sat();
        do_reset(1);
        for (int i = 0; i < 264; i++) drive(0, 1, 16'd2, 0, 0);
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_sat got %0d exp 255", drop_cnt); end
    endtask

    task automatic test_random();
        do_reset(1);
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), 16'($urandom),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0));
            checks++;
            if (e !== exp_head() || e_valid !== (m_q.size() != 0) || count !== 3'(m_q.size()) ||
                full !== (m_q.size() == DEPTH) || ovf !== m_ovf || drop_cnt !== 8'(m_drop)) begin
                errors++;
                $display("FAIL rand[%0d] got e=%0h v=%b c=%0d f=%b o=%b dr=%0d exp e=%0h c=%0d o=%b dr=%0d",
                         i, e, e_valid, count, full, ovf, drop_cnt, exp_head(), m_q.size(), m_ovf, m_drop);
            end
        end
    endtask

    initial begin
        rst = 1; d = '0; d_valid = 0; clr = 0; e_ready = 0;
        test_reset();
        test_stream();
        test_full_drain();
        test_full_push_pop();
        test_wrap();
        test_clear();
        test_mid_reset();
        test_drop_sat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
